// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced presses into short, long and double events.
// Times each hold and each inter-press gap; every output is registered.
module press_classifier #(
   parameter int CNT_W       = 16,
   parameter int LONG_CYCLES = 16,
   parameter int GAP_CYCLES  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clean,
   output logic             short_press,
   output logic             long_press,
   output logic             double_press,
   output logic             long_hold,
   output logic [CNT_W-1:0] press_len,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HELD = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] GAP_V   = CNT_W'(GAP_CYCLES);

   logic [1:0]       state;
   logic             clean_d;
   logic             second;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] gcnt;
   logic [CNT_W-1:0] plen_q;
   logic             rise;
   logic             fall;

   assign rise = clean & ~clean_d;
   assign fall = ~clean & clean_d;

   // clean_d resets high so a button held across reset release does not look like a new press
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         clean_d      <= 1'b1;
         second       <= 1'b0;
         hcnt         <= '0;
         gcnt         <= '0;
         plen_q       <= '0;
         press_len    <= '0;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_press <= 1'b0;
         long_hold    <= 1'b0;
      end else begin
         clean_d      <= clean;
         short_press  <= 1'b0;
         long_press   <= 1'b0;
         double_press <= 1'b0;
         long_hold    <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  state  <= HELD;
                  busy   <= 1'b1;
                  hcnt   <= ONE;
                  second <= 1'b0;
               end
            end
            HELD: begin
               if (fall) begin
                  if (second) begin
                     double_press <= 1'b1;
                     press_len    <= hcnt;
                     state        <= IDLE;
                     busy         <= 1'b0;
                  end else if (hcnt >= LONG_V) begin
                     long_press <= 1'b1;
                     press_len  <= hcnt;
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end else begin
                     plen_q <= hcnt;
                     gcnt   <= ONE;
                     state  <= GAP;
                  end
               end else begin
                  if (hcnt != CNT_MAX) hcnt <= hcnt + ONE;
                  // LONG_CYCLES is below CNT_MAX, so this step is always a real increment
                  if (!second && hcnt == LONG_V - ONE) long_hold <= 1'b1;
               end
            end
            GAP: begin
               if (rise) begin
                  state  <= HELD;
                  hcnt   <= ONE;
                  second <= 1'b1;
               end else if (gcnt == GAP_V) begin
                  short_press <= 1'b1;
                  press_len   <= plen_q;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end else begin
                  gcnt <= gcnt + ONE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - scoreboard bench for press_classifier, default and narrow-counter instances.
module tb_press_classifier;

   typedef struct {
      int kind;
      int len;
      int cyc;
   } ev_t;

   localparam int K_SHORT  = 0;
   localparam int K_LONG   = 1;
   localparam int K_DOUBLE = 2;
   localparam int K_HOLD   = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        clean;
   logic        clean_b;
   logic        sa, la, da, ha, busy_a;
   logic [15:0] len_a;
   logic        sb, lb, db, hb, busy_b;
   logic [3:0]  len_b;

   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   ev_t  qa[$];
   ev_t  qb[$];

   press_classifier dut_a (
      .clock(clock), .reset(reset), .clean(clean),
      .short_press(sa), .long_press(la), .double_press(da), .long_hold(ha),
      .press_len(len_a), .busy(busy_a)
   );

   press_classifier #(.CNT_W(4), .LONG_CYCLES(8), .GAP_CYCLES(8)) dut_b (
      .clock(clock), .reset(reset), .clean(clean_b),
      .short_press(sb), .long_press(lb), .double_press(db), .long_hold(hb),
      .press_len(len_b), .busy(busy_b)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic hold(input logic v, input int n);
      clean = v;
      repeat (n) @(negedge clock);
   endtask

   // scoreboard for the default instance: each observed pulse pops one expectation
   always @(negedge clock) begin
      int  n;
      int  kind;
      ev_t e;
      n = int'(sa) + int'(la) + int'(da) + int'(ha);
      if (n != 0) begin
         kind = sa ? K_SHORT : la ? K_LONG : da ? K_DOUBLE : K_HOLD;
         chk("a_single_pulse", n, 1);
         if (qa.size() == 0) begin
            chk("a_unexpected_event", kind, -1);
         end else begin
            e = qa.pop_front();
            chk("a_kind", kind, e.kind);
            chk("a_cycle", cyc, e.cyc);
            if (e.kind != K_HOLD) chk("a_press_len", int'(len_a), e.len);
         end
      end
   end

   always @(negedge clock) begin
      int  n;
      int  kind;
      ev_t e;
      n = int'(sb) + int'(lb) + int'(db) + int'(hb);
      if (n != 0) begin
         kind = sb ? K_SHORT : lb ? K_LONG : db ? K_DOUBLE : K_HOLD;
         chk("b_single_pulse", n, 1);
         if (qb.size() == 0) begin
            chk("b_unexpected_event", kind, -1);
         end else begin
            e = qb.pop_front();
            chk("b_kind", kind, e.kind);
            chk("b_cycle", cyc, e.cyc);
            if (e.kind != K_HOLD) chk("b_press_len", int'(len_b), e.len);
         end
      end
   end

   initial begin
      int r;
      int f;
      int f1;
      reset   = 1'b0;
      clean   = 1'b0;
      clean_b = 1'b0;

      // reset with clean toggling
      for (int i = 0; i < 3; i++) begin
         clean = ~clean;
         @(negedge clock);
         chk("rst_pulses", int'(sa) + int'(la) + int'(da) + int'(ha), 0);
         chk("rst_len", int'(len_a), 0);
         chk("rst_busy", int'(busy_a), 0);
      end
      clean = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("post_rst_busy", int'(busy_a), 0);

      // single short press of 5
      clean = 1'b1;
      repeat (5) @(negedge clock);
      chk("short_busy_held", int'(busy_a), 1);
      f = cyc + 1;
      qa.push_back('{K_SHORT, 5, f + 8});
      hold(1'b0, 8);
      chk("short_busy_gap", int'(busy_a), 1);
      hold(1'b0, 1);
      chk("short_pulse", int'(sa), 1);
      chk("short_busy_done", int'(busy_a), 0);
      hold(1'b0, 12);
      chk("len_holds", int'(len_a), 5);
      chk("short_pending", qa.size(), 0);

      // long press of 20
      r = cyc + 1;
      qa.push_back('{K_HOLD, 0, r + 15});
      hold(1'b1, 20);
      f = cyc + 1;
      qa.push_back('{K_LONG, 20, f});
      hold(1'b0, 20);
      chk("long_pending", qa.size(), 0);

      // double press: 4 high, 3 low, 6 high
      hold(1'b1, 4);
      hold(1'b0, 3);
      hold(1'b1, 6);
      f = cyc + 1;
      qa.push_back('{K_DOUBLE, 6, f});
      hold(1'b0, 20);
      chk("double_pending", qa.size(), 0);

      // rise lands on the gap-expiry edge: rise wins, still a double
      hold(1'b1, 4);
      hold(1'b0, 8);
      hold(1'b1, 6);
      f = cyc + 1;
      qa.push_back('{K_DOUBLE, 6, f});
      hold(1'b0, 20);
      chk("collide_pending", qa.size(), 0);

      // gap one cycle longer: two separate short presses
      hold(1'b1, 4);
      f1 = cyc + 1;
      qa.push_back('{K_SHORT, 4, f1 + 8});
      hold(1'b0, 9);
      hold(1'b1, 6);
      f = cyc + 1;
      qa.push_back('{K_SHORT, 6, f + 8});
      hold(1'b0, 20);
      chk("two_short_pending", qa.size(), 0);

      // narrow counter: saturating press length, one long_hold
      r = cyc + 1;
      qb.push_back('{K_HOLD, 0, r + 7});
      clean_b = 1'b1;
      repeat (30) @(negedge clock);
      chk("sat_busy", int'(busy_b), 1);
      f = cyc + 1;
      qb.push_back('{K_LONG, 15, f});
      clean_b = 1'b0;
      repeat (20) @(negedge clock);
      chk("sat_pending", qb.size(), 0);

      // reset mid-press with button held through release
      hold(1'b1, 3);
      chk("mid_busy", int'(busy_a), 1);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("mid_rst_busy", int'(busy_a), 0);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("held_after_rst_busy", int'(busy_a), 0);
      end
      hold(1'b0, 3);
      chk("released_busy", int'(busy_a), 0);
      hold(1'b1, 5);
      f = cyc + 1;
      qa.push_back('{K_SHORT, 5, f + 8});
      hold(1'b0, 20);

      chk("final_pending_a", qa.size(), 0);
      chk("final_pending_b", qb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
